// File: rtl/pll_drp_sequencer.sv
// Run-time CLKOUT0 divide reconfiguration for a PLLE2_ADV over DRP.
// Also owns the PLL reset and the downstream system reset.
module pll_drp_sequencer #(
    parameter logic [6:0] CLKOUT0_DIV_INIT = 7'd48,
    parameter logic [6:0] REG1_ADDR        = 7'h08,
    parameter logic [6:0] REG2_ADDR        = 7'h09,
    parameter int         DRDY_TIMEOUT     = 64,
    parameter int         LOCK_STABLE      = 16
) (
    input  logic        IO_CLK,
    input  logic        IO_RST_N,
    input  logic        cfg_req_i,
    input  logic [6:0]  cfg_div_i,
    output logic        cfg_ack_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [6:0]  cur_div_o,
    output logic [6:0]  drp_addr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    input  logic        drp_drdy_i,
    output logic        pll_rst_o,
    input  logic        pll_locked_i,
    output logic        rst_sys_n_o
);
    localparam int TO_W = $clog2(DRDY_TIMEOUT + 1);
    localparam int LK_W = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {
        IDLE, PLL_RST, RD, RD_WAIT, WR, WR_WAIT, NEXT, WAIT_LOCK
    } state_t;

    typedef struct packed {
        state_t            state;
        logic              pll_rst;
        logic              den;
        logic              dwe;
        logic [6:0]        addr;
        logic [15:0]       di;
        logic              ack;
        logic              err;
        logic [6:0]        cur_div;
        logic              rst_sys_n;
        logic [LK_W-1:0]   lock_cnt;
        logic [6:0]        div;
        logic              reg2_sel;
        logic [15:0]       rd_word;
        logic [TO_W-1:0]   to_cnt;
        logic              to_hit;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        state:     WAIT_LOCK,
        pll_rst:   1'b0,
        den:       1'b0,
        dwe:       1'b0,
        addr:      7'd0,
        di:        16'd0,
        ack:       1'b0,
        err:       1'b0,
        cur_div:   CLKOUT0_DIV_INIT,
        rst_sys_n: 1'b0,
        lock_cnt:  '0,
        div:       CLKOUT0_DIV_INIT,
        reg2_sel:  1'b0,
        rd_word:   16'd0,
        to_cnt:    '0,
        to_hit:    1'b0
    };

    // ClkReg1: high/low counts; divide 1 is expressed as 1/1 with the counter bypassed.
    function automatic logic [15:0] merge_reg1(input logic [6:0] d, input logic [15:0] rd);
        logic [5:0] hi;
        logic [5:0] lo;
        hi = d[6:1];
        lo = 6'(d - {1'b0, d[6:1]});
        if (d == 7'd1) begin
            hi = 6'd1;
            lo = 6'd1;
        end
        return {rd[15:12], hi, lo};
    endfunction

    // ClkReg2: edge (bit 7) marks odd divides; divide 1 uses no_count (bit 6) instead.
    function automatic logic [15:0] merge_reg2(input logic [6:0] d, input logic [15:0] rd);
        logic edge_bit;
        logic nocnt;
        nocnt    = (d == 7'd1);
        edge_bit = d[0] & ~nocnt;
        return {rd[15:8], edge_bit, nocnt, rd[5:0]};
    endfunction

    // NOTE: PLL LOCKED is asynchronous to IO_CLK; two flops before any decision uses it.
    logic lock_meta;
    logic lock_sync;

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked_i;
            lock_sync <= lock_meta;
        end
    end

    regs_t r;
    regs_t n;

    // NOTE: state registers use non-blocking assignment; all next values come from always_comb.
    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) r <= REGS_RESET;
        else           r <= n;
    end

    always_comb begin
        n     = r;
        n.ack = 1'b0;
        n.den = 1'b0;
        n.dwe = 1'b0;

        case (r.state)
            IDLE: begin
                if (!lock_sync) begin
                    n.rst_sys_n = 1'b0;
                    n.lock_cnt  = '0;
                    n.state     = WAIT_LOCK;
                end else if (cfg_req_i) begin
                    n.ack = 1'b1;
                    if (cfg_div_i == 7'd0 || cfg_div_i == 7'h7F) begin
                        n.err = 1'b1;
                    end else begin
                        n.err    = 1'b0;
                        n.div    = cfg_div_i;
                        n.to_hit = 1'b0;
                        n.state  = PLL_RST;
                    end
                end
            end

            PLL_RST: begin
                n.pll_rst   = 1'b1;
                n.rst_sys_n = 1'b0;
                n.reg2_sel  = 1'b0;
                n.state     = RD;
            end

            RD: begin
                n.den    = 1'b1;
                n.addr   = r.reg2_sel ? REG2_ADDR : REG1_ADDR;
                n.to_cnt = '0;
                n.state  = RD_WAIT;
            end

            WR: begin
                n.den    = 1'b1;
                n.dwe    = 1'b1;
                n.di     = r.reg2_sel ? merge_reg2(r.div, r.rd_word)
                                      : merge_reg1(r.div, r.rd_word);
                n.to_cnt = '0;
                n.state  = WR_WAIT;
            end

            RD_WAIT, WR_WAIT: begin
                if (drp_drdy_i) begin
                    if (r.state == RD_WAIT) begin
                        n.rd_word = drp_do_i;
                        n.state   = WR;
                    end else begin
                        n.state = NEXT;
                    end
                end else if (r.to_cnt == TO_W'(DRDY_TIMEOUT - 1)) begin
                    // Abandon the sequence; the PLL is released so it can relock on whatever it holds.
                    n.err      = 1'b1;
                    n.to_hit   = 1'b1;
                    n.pll_rst  = 1'b0;
                    n.lock_cnt = '0;
                    n.state    = WAIT_LOCK;
                end else begin
                    n.to_cnt = r.to_cnt + 1'b1;
                end
            end

            NEXT: begin
                if (!r.reg2_sel) begin
                    n.reg2_sel = 1'b1;
                    n.state    = RD;
                end else begin
                    n.pll_rst  = 1'b0;
                    n.lock_cnt = '0;
                    n.state    = WAIT_LOCK;
                end
            end

            WAIT_LOCK: begin
                n.rst_sys_n = 1'b0;
                if (!lock_sync) begin
                    n.lock_cnt = '0;
                end else if (r.lock_cnt == LK_W'(LOCK_STABLE - 1)) begin
                    n.lock_cnt  = '0;
                    n.rst_sys_n = 1'b1;
                    if (!r.to_hit) n.cur_div = r.div;
                    n.state = IDLE;
                end else begin
                    n.lock_cnt = r.lock_cnt + 1'b1;
                end
            end

            default: n.state = WAIT_LOCK;
        endcase
    end

    assign cfg_ack_o   = r.ack;
    assign busy_o      = (r.state != IDLE);
    assign err_o       = r.err;
    assign cur_div_o   = r.cur_div;
    assign drp_addr_o  = r.addr;
    assign drp_di_o    = r.di;
    assign drp_den_o   = r.den;
    assign drp_dwe_o   = r.dwe;
    assign pll_rst_o   = r.pll_rst;
    assign rst_sys_n_o = r.rst_sys_n;

endmodule
